// File: rtl/reg_file_unit_pkg.sv
// Shared register-file package: default geometry and address-width derivation.
// Imported by reg_file_unit and reg_file_read_port.

package reg_file_unit_pkg;

    localparam int DEF_WORD_LENGTH = 32;
    localparam int DEF_REG_COUNT   = 16;

    // Address width for a power-of-two register count (REG_COUNT = 2..64).
    function automatic int calcAdrW(input int regCount);
        return $clog2(regCount);
    endfunction

    localparam int DEF_ADR_W = calcAdrW(DEF_REG_COUNT);

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: address mux, optional write bypass, output register.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write data.

module reg_file_read_port
    import reg_file_unit_pkg::*;
#(
    parameter  int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter  int REG_COUNT   = DEF_REG_COUNT,
    localparam int ADR_W       = calcAdrW(REG_COUNT)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rdEn,
    input  logic [ADR_W-1:0]       i_rdAdr,
    input  logic [WORD_LENGTH-1:0] i_regs [REG_COUNT],
    input  logic [REG_COUNT-1:0]   i_pending,
    input  logic                   i_wrEn,
    input  logic [ADR_W-1:0]       i_wrAdr,
    input  logic [WORD_LENGTH-1:0] i_wrData,
    input  logic                   i_resEn,
    input  logic [ADR_W-1:0]       i_resAdr,
    output logic [WORD_LENGTH-1:0] o_rdData,
    output logic                   o_rdValid
);

    logic [WORD_LENGTH-1:0] w_selData;
    logic                   w_selValid;
    logic [WORD_LENGTH-1:0] r_rdData;
    logic                   r_rdValid;

`ifndef REG_FILE_BYPASS_EN
    logic w_unusedBypass;
    assign w_unusedBypass = ^{i_wrEn, i_wrAdr, i_wrData, i_resEn, i_resAdr};
`endif

    // Register 0 is hard-wired to zero and never pending, whatever the array holds.
    always_comb begin
        w_selData  = i_regs[i_rdAdr];
        w_selValid = ~i_pending[i_rdAdr];
        if (i_rdAdr == '0) begin
            w_selData  = '0;
            w_selValid = 1'b1;
        end
`ifdef REG_FILE_BYPASS_EN
        else if (i_wrEn && (i_wrAdr == i_rdAdr)) begin
            w_selData  = i_wrData;
            w_selValid = !(i_resEn && (i_resAdr == i_rdAdr));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else if (i_rdEn) begin
            r_rdData  <= w_selData;
            r_rdValid <= w_selValid;
        end
    end

    assign o_rdData  = r_rdData;
    assign o_rdValid = r_rdValid;

endmodule

// File: rtl/reg_file_unit.sv
// Register file with per-register pending (scoreboard) bits and two registered read ports.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle writes to reads.

module reg_file_unit
    import reg_file_unit_pkg::*;
#(
    parameter  int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter  int REG_COUNT   = DEF_REG_COUNT,
    localparam int ADR_W       = calcAdrW(REG_COUNT)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdEnA,
    input  logic [ADR_W-1:0]       rdAdrA,
    output logic [WORD_LENGTH-1:0] rdDataA,
    output logic                   rdValidA,
    input  logic                   rdEnB,
    input  logic [ADR_W-1:0]       rdAdrB,
    output logic [WORD_LENGTH-1:0] rdDataB,
    output logic                   rdValidB,
    input  logic                   wrEn,
    input  logic [ADR_W-1:0]       wrAdr,
    input  logic [WORD_LENGTH-1:0] wrData,
    input  logic                   resEn,
    input  logic [ADR_W-1:0]       resAdr,
    output logic [REG_COUNT-1:0]   pendMask
);

    logic [WORD_LENGTH-1:0] r_regs [REG_COUNT];
    logic [REG_COUNT-1:0]   r_pending;
    logic [REG_COUNT-1:0]   w_pendNext;

    // Reserve is applied after the write-clear so it wins on a same-register collision.
    always_comb begin
        w_pendNext = r_pending;
        if (wrEn) begin
            w_pendNext[wrAdr] = 1'b0;
        end
        if (resEn) begin
            w_pendNext[resAdr] = 1'b1;
        end
        w_pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            if (wrEn && (wrAdr != '0)) begin
                r_regs[wrAdr] <= wrData;
            end
            r_pending <= w_pendNext;
        end
    end

    assign pendMask = r_pending;

    reg_file_read_port #(
        .WORD_LENGTH (WORD_LENGTH),
        .REG_COUNT   (REG_COUNT)
    ) u_readPortA (
        .clk       (clk),
        .rst       (rst),
        .i_rdEn    (rdEnA),
        .i_rdAdr   (rdAdrA),
        .i_regs    (r_regs),
        .i_pending (r_pending),
        .i_wrEn    (wrEn),
        .i_wrAdr   (wrAdr),
        .i_wrData  (wrData),
        .i_resEn   (resEn),
        .i_resAdr  (resAdr),
        .o_rdData  (rdDataA),
        .o_rdValid (rdValidA)
    );

    reg_file_read_port #(
        .WORD_LENGTH (WORD_LENGTH),
        .REG_COUNT   (REG_COUNT)
    ) u_readPortB (
        .clk       (clk),
        .rst       (rst),
        .i_rdEn    (rdEnB),
        .i_rdAdr   (rdAdrB),
        .i_regs    (r_regs),
        .i_pending (r_pending),
        .i_wrEn    (wrEn),
        .i_wrAdr   (wrAdr),
        .i_wrData  (wrData),
        .i_resEn   (resEn),
        .i_resAdr  (resAdr),
        .o_rdData  (rdDataB),
        .o_rdValid (rdValidB)
    );

endmodule

// File: tb/tb_reg_file_unit.sv
// Directed testbench for reg_file_unit (default geometry: 32-bit words, 16 registers).
// Expected values for same-cycle write/read depend on REG_FILE_BYPASS_EN.

module tb_reg_file_unit;

    logic        clk;
    logic        rst;
    logic        rdEnA, rdEnB, wrEn, resEn;
    logic [3:0]  rdAdrA, rdAdrB, wrAdr, resAdr;
    logic [31:0] wrData;
    logic [31:0] rdDataA, rdDataB;
    logic        rdValidA, rdValidB;
    logic [15:0] pendMask;

    int checks = 0;
    int errors = 0;

    reg_file_unit #(
        .WORD_LENGTH (32),
        .REG_COUNT   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdEnA    (rdEnA),
        .rdAdrA   (rdAdrA),
        .rdDataA  (rdDataA),
        .rdValidA (rdValidA),
        .rdEnB    (rdEnB),
        .rdAdrB   (rdAdrB),
        .rdDataB  (rdDataB),
        .rdValidB (rdValidB),
        .wrEn     (wrEn),
        .wrAdr    (wrAdr),
        .wrData   (wrData),
        .resEn    (resEn),
        .resAdr   (resAdr),
        .pendMask (pendMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic eA, input logic [3:0] aA,
                                 input logic eB, input logic [3:0] aB,
                                 input logic eW, input logic [3:0] aW, input logic [31:0] dW,
                                 input logic eR, input logic [3:0] aR);
        rdEnA = eA; rdAdrA = aA;
        rdEnB = eB; rdAdrB = aB;
        wrEn = eW; wrAdr = aW; wrData = dW;
        resEn = eR; resAdr = aR;
        @(posedge clk);
        #1;
        rdEnA = 1'b0; rdEnB = 1'b0; wrEn = 1'b0; resEn = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] expSameCycle;
        logic [31:0] expResWrData;
        logic        expResWrValid;
`ifdef REG_FILE_BYPASS_EN
        expSameCycle  = 32'hA5;
        expResWrData  = 32'h77;
        expResWrValid = 1'b0;
`else
        expSameCycle  = 32'h11;
        expResWrData  = 32'h0;
        expResWrValid = 1'b1;
`endif
        rst = 1'b0;
        rdEnA = 1'b0; rdEnB = 1'b0; wrEn = 1'b0; resEn = 1'b0;
        rdAdrA = '0; rdAdrB = '0; wrAdr = '0; resAdr = '0; wrData = '0;

        #12;
        checkOutput("reset rdDataA", rdDataA, 0);
        checkOutput("reset rdValidA", rdValidA, 0);
        checkOutput("reset rdValidB", rdValidB, 0);
        checkOutput("reset pendMask", pendMask, 0);
        @(negedge clk);
        rst = 1'b1;

        // Write then read back with one-cycle latency
        applyStimulus(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("read5 data", rdDataA, 32'hDEADBEEF);
        checkOutput("read5 valid", rdValidA, 1);

        // Port holds while rdEn is low
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hold data", rdDataA, 32'hDEADBEEF);

        // Register 0 ignores writes
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("reg0 data", rdDataB, 0);
        checkOutput("reg0 valid", rdValidB, 1);
        checkOutput("reg0 pend", pendMask[0], 0);

        // Reserve then write clears pending
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3);
        checkOutput("res3 pendMask", pendMask, 16'h0008);
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("res3 valid", rdValidA, 0);
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h55, 0, 0);
        checkOutput("wr3 pendMask", pendMask, 0);
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr3 data", rdDataA, 32'h55);
        checkOutput("wr3 valid", rdValidA, 1);

        // Both ports on the same register
        applyStimulus(1, 5, 1, 5, 0, 0, 0, 0, 0);
        checkOutput("dual A", rdDataA, 32'hDEADBEEF);
        checkOutput("dual B", rdDataB, 32'hDEADBEEF);
        checkOutput("dual validB", rdValidB, 1);

        // Same-cycle write and read
        applyStimulus(0, 0, 0, 0, 1, 7, 32'h11, 0, 0);
        applyStimulus(1, 7, 0, 0, 1, 7, 32'hA5, 0, 0);
        checkOutput("samecyc data", rdDataA, expSameCycle);
        checkOutput("samecyc valid", rdValidA, 1);
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("after wr7", rdDataA, 32'hA5);

        // Same-cycle reserve and write: reserve wins
        applyStimulus(0, 0, 1, 9, 1, 9, 32'h77, 1, 9);
        checkOutput("reswr pendMask", pendMask, 16'h0200);
        checkOutput("reswr samecyc data", rdDataB, expResWrData);
        checkOutput("reswr samecyc valid", rdValidB, expResWrValid);
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reswr data", rdDataA, 32'h77);
        checkOutput("reswr valid", rdValidA, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
        checkOutput("re-reserve", pendMask, 16'h0200);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("reserve reg0", pendMask, 16'h0200);

        // Asynchronous reset mid-stream
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 1, 6, 32'h99, 0, 0);
        applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pre-rst data", rdDataA, 32'h99);
        checkOutput("pre-rst pend", pendMask, 16'h0210);
        rdEnA = 1'b1; rdAdrA = 5; wrEn = 1'b1; wrAdr = 8; wrData = 32'h1;
        resEn = 1'b1; resAdr = 10;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async rst data", rdDataA, 0);
        checkOutput("async rst valid", rdValidA, 0);
        checkOutput("async rst pend", pendMask, 0);
        #10;
        @(negedge clk);
        rst = 1'b1;
        rdEnA = 1'b0; wrEn = 1'b0; resEn = 1'b0;
        applyStimulus(1, 4, 1, 5, 0, 0, 0, 0, 0);
        checkOutput("post-rst A data", rdDataA, 0);
        checkOutput("post-rst A valid", rdValidA, 1);
        checkOutput("post-rst B data", rdDataB, 0);
        checkOutput("post-rst B valid", rdValidB, 1);
        checkOutput("post-rst pend", pendMask, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
